rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the register file's single write port (we3/wa3/wd3) between two writeback
//   requesters: A = ALU/execute pipe, B = load/store unit.
//   Arbitrates per cycle with valid/ready and round-robin on ties, then registers the
//   winning write one cycle before it reaches the register file.
//   Drops writes to x0 and exposes a two-lookup forwarding check against the staged write.
//   Sits between the pipeline writeback stage and the three-ported register file.
// PARAMETERS
//   XLEN         32  data width of a register write
//   RFIDX_WIDTH  5   register index width (2**RFIDX_WIDTH registers)
//   CNT_WIDTH    16  width of the committed-write counter
// PORTS
//   clk        in   1            system clock, all state updates on posedge
//   reset      in   1            synchronous, active-high reset
//   hold       in   1            1 = grant nothing this cycle (writeback freeze)
//   a_valid    in   1            requester A has a write
//   a_idx      in   RFIDX_WIDTH  requester A destination register
//   a_data     in   XLEN         requester A write data
//   a_ready    out  1            requester A write accepted this cycle (combinational)
//   b_valid    in   1            requester B has a write
//   b_idx      in   RFIDX_WIDTH  requester B destination register
//   b_data     in   XLEN         requester B write data
//   b_ready    out  1            requester B write accepted this cycle (combinational)
//   we3        out  1            register-file write enable (registered)
//   wa3        out  RFIDX_WIDTH  register-file write address (registered)
//   wd3        out  XLEN         register-file write data (registered)
//   fwd_idx1   in   RFIDX_WIDTH  forwarding lookup index 1
//   fwd_hit1   out  1            staged write targets fwd_idx1 (combinational)
//   fwd_data1  out  XLEN         staged data for lookup 1 (wd3 when hit, else 0)
//   fwd_idx2   in   RFIDX_WIDTH  forwarding lookup index 2
//   fwd_hit2   out  1            staged write targets fwd_idx2 (combinational)
//   fwd_data2  out  XLEN         staged data for lookup 2 (wd3 when hit, else 0)
//   wr_count   out  CNT_WIDTH    number of writes committed with we3=1; wraps
// BEHAVIOUR
// - Reset (synchronous): we3=0, wa3=0, wd3=0, wr_count=0, last_grant=B.
//   With last_grant=B, A wins the first tie. Any write staged at reset is discarded.
// - Grant is combinational and has two states: last_grant in {A, B}.
//     hold=1: a_ready=b_ready=0.
//     Only one requester valid: that requester is granted.
//     Both valid: grant the requester that is not last_grant.
//     ready is asserted only together with the matching valid.
// - last_grant updates on every posedge where a grant occurred, including grants to x0.
// - Output stage is registered, latency 1 cycle from handshake to we3.
//     we3 <= granted && granted_idx!=0.
//     wa3/wd3 <= granted idx/data when granted; otherwise they hold their previous values.
// - The register file samples the write on the following negedge, so the write is
//   architecturally visible half a cycle after we3 rises.
// - Throughput: one write per cycle, no bubbles. A loser of a tie waits at most 1 cycle.
// - x0 writes are handshaken (ready=1) but never assert we3 and never count.
// - wr_count increments by 1 at each posedge where we3 is 1 in the preceding cycle,
//   i.e. once per committed write. Wraps from 2**CNT_WIDTH-1 to 0.
// - Forwarding: fwd_hitN = we3 && (wa3==fwd_idxN) && (fwd_idxN!=0).
//   fwd_dataN = fwd_hitN ? wd3 : 0. Both lookups are independent and may alias.
// - Same index from A and B in consecutive cycles is kept in grant order, so the later
//   write wins in the register file.
// - hold asserted while we3=1: the staged write still commits; we3 drops the next cycle.
// - Requesters must keep idx/data stable while valid && !ready. Behaviour is undefined
//   if they do not.
// TESTING
// 1. Reset, then a_valid only, a_idx=5, a_data=0xDEADBEEF.
//    -> a_ready=1 that cycle; next cycle we3=1, wa3=5, wd3=DEADBEEF; wr_count=1 after.
// 2. A and B valid for 4 cycles (A idx 1..4, B idx 11..14).
//    -> grants alternate A,B,A,B starting with A; we3 continuous.
// 3. a_idx=0 valid.
//    -> a_ready=1; we3 stays 0; wr_count unchanged; fwd_hit for idx 0 stays 0.
// 4. hold=1 with both valid for 3 cycles.
//    -> ready=0 for both, we3=0 from cycle 2; release -> A (not last_grant) granted first.
// 5. we3=1, wa3=7; fwd_idx1=7, fwd_idx2=8.
//    -> fwd_hit1=1, fwd_data1=wd3; fwd_hit2=0, fwd_data2=0.
// 6. reset asserted while a write is staged.
//    -> next cycle we3=0, wr_count=0; the staged write is never committed.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: round-robin
// between ALU (A) and LSU (B), one registered stage, x0 drop, two forwarding lookups.
module rf_wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   a_valid,
  input  logic [RFIDX_WIDTH-1:0] a_idx,
  input  logic [XLEN-1:0]        a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [RFIDX_WIDTH-1:0] b_idx,
  input  logic [XLEN-1:0]        b_data,
  output logic                   b_ready,
  output logic                   we3,
  output logic [RFIDX_WIDTH-1:0] wa3,
  output logic [XLEN-1:0]        wd3,
  input  logic [RFIDX_WIDTH-1:0] fwd_idx1,
  output logic                   fwd_hit1,
  output logic [XLEN-1:0]        fwd_data1,
  input  logic [RFIDX_WIDTH-1:0] fwd_idx2,
  output logic                   fwd_hit2,
  output logic [XLEN-1:0]        fwd_data2,
  output logic [CNT_WIDTH-1:0]   wr_count
);

  logic                   r_last_b;
  logic                   r_we3;
  logic [RFIDX_WIDTH-1:0] r_wa3;
  logic [XLEN-1:0]        r_wd3;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic                   w_gnt_a;
  logic                   w_gnt_b;
  logic                   w_gnt;
  logic [RFIDX_WIDTH-1:0] w_idx;
  logic [XLEN-1:0]        w_data;

  // On a tie the requester that did not win last time goes first.
  assign w_gnt_a = !hold && a_valid && (!b_valid ||  r_last_b);
  assign w_gnt_b = !hold && b_valid && (!a_valid || !r_last_b);
  assign w_gnt   = w_gnt_a || w_gnt_b;
  assign w_idx   = w_gnt_a ? a_idx  : b_idx;
  assign w_data  = w_gnt_a ? a_data : b_data;

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
      r_we3    <= 1'b0;
      r_wa3    <= '0;
      r_wd3    <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_gnt) begin
        r_last_b <= w_gnt_b;
        r_wa3    <= w_idx;
        r_wd3    <= w_data;
      end
      // x0 writes are accepted but never reach the register file.
      r_we3 <= w_gnt && (w_idx != '0);
      if (r_we3) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign we3      = r_we3;
  assign wa3      = r_wa3;
  assign wd3      = r_wd3;
  assign wr_count = r_cnt;

  assign fwd_hit1  = r_we3 && (r_wa3 == fwd_idx1) && (fwd_idx1 != '0);
  assign fwd_data1 = fwd_hit1 ? r_wd3 : '0;
  assign fwd_hit2  = r_we3 && (r_wa3 == fwd_idx2) && (fwd_idx2 != '0);
  assign fwd_data2 = fwd_hit2 ? r_wd3 : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; a 3-bit write counter makes the wrap reachable.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            reset, hold;
  logic            a_valid, b_valid, a_ready, b_ready;
  logic [RW-1:0]   a_idx, b_idx, wa3, fwd_idx1, fwd_idx2;
  logic [XLEN-1:0] a_data, b_data, wd3, fwd_data1, fwd_data2;
  logic            we3, fwd_hit1, fwd_hit2;
  logic [CW-1:0]   wr_count;

  int n_pass = 0;
  int n_tot  = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_idx(a_idx), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_idx(b_idx), .b_data(b_data), .b_ready(b_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .fwd_idx1(fwd_idx1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_idx2(fwd_idx2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b0; a_idx = '0; a_data = '0;
    b_valid = 1'b0; b_idx = '0; b_data = '0;
    fwd_idx1 = '0; fwd_idx2 = '0;
    tick(); tick();
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_cnt", wr_count, 0);
    reset = 1'b0;

    // single A write
    a_valid = 1'b1; a_idx = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    chk("t1_we3", we3, 1);
    chk("t1_wa3", wa3, 5);
    chk("t1_wd3", wd3, 32'hDEADBEEF);
    chk("t1_cnt0", wr_count, 0);
    tick();
    chk("t1_cnt1", wr_count, 1);
    chk("t1_we3_off", we3, 0);

    // single B write, leaves last_grant = B
    b_valid = 1'b1; b_idx = 5'd9; b_data = 32'h0000_0099;
    #1;
    chk("tb_b_ready", b_ready, 1);
    chk("tb_a_ready", a_ready, 0);
    tick();
    chk("tb_wa3", wa3, 9);
    chk("tb_wd3", wd3, 32'h99);

    // both valid: A,B,A,B; each requester holds until accepted
    a_valid = 1'b1; a_idx = 5'd1;  a_data = 32'hA000_0001;
    b_valid = 1'b1; b_idx = 5'd11; b_data = 32'hB000_000B;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_a_ready", a_ready, (c % 2 == 0));
      chk("t2_b_ready", b_ready, (c % 2 == 1));
      tick();
      chk("t2_we3", we3, 1);
      if (c % 2 == 0) begin
        chk("t2_wa3_a", wa3, 1 + c / 2);
        chk("t2_wd3_a", wd3, 32'hA000_0000 | (1 + c / 2));
        a_idx = a_idx + 1'b1; a_data = 32'hA000_0000 | a_idx;
      end else begin
        chk("t2_wa3_b", wa3, 11 + c / 2);
        chk("t2_wd3_b", wd3, 32'hB000_0000 | (11 + c / 2));
        b_idx = b_idx + 1'b1; b_data = 32'hB000_0000 | b_idx;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_cnt", wr_count, 5);

    // x0 write: handshaken, never enables, never counts
    a_valid = 1'b1; a_idx = 5'd0; a_data = 32'h0000_1234; fwd_idx1 = 5'd0;
    #1;
    chk("t3_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("t3_we3", we3, 0);
    chk("t3_wa3", wa3, 0);
    chk("t3_fwd_hit0", fwd_hit1, 0);
    chk("t3_cnt", wr_count, 6);
    tick();
    chk("t3_cnt_hold", wr_count, 6);

    // B write so last_grant = B, then hold with both valid
    b_valid = 1'b1; b_idx = 5'd20; b_data = 32'h2020_2020;
    tick();
    a_valid = 1'b1; a_idx = 5'd3;  a_data = 32'hA000_0003;
    b_valid = 1'b1; b_idx = 5'd13; b_data = 32'hB000_000D;
    hold = 1'b1;
    #1;
    chk("t4_hold_a0", a_ready, 0);
    chk("t4_hold_b0", b_ready, 0);
    chk("t4_staged_we3", we3, 1);
    tick();
    chk("t4_cnt_commit", wr_count, 7);
    chk("t4_we3_c2", we3, 0);
    chk("t4_hold_a1", a_ready, 0);
    tick();
    chk("t4_we3_c3", we3, 0);
    chk("t4_hold_b2", b_ready, 0);
    tick();
    hold = 1'b0;
    #1;
    chk("t4_rel_a", a_ready, 1);
    chk("t4_rel_b", b_ready, 0);
    tick();
    a_valid = 1'b0;
    chk("t4_wa3_a", wa3, 3);
    chk("t4_b_next", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("t4_wa3_b", wa3, 13);
    chk("t4_cnt_wrap", wr_count, 0);  // 8 writes on a 3-bit counter

    // forwarding against wa3=7
    a_valid = 1'b1; a_idx = 5'd7; a_data = 32'h7777_0007;
    fwd_idx1 = 5'd7; fwd_idx2 = 5'd8;
    tick();
    a_valid = 1'b0;
    chk("t5_hit1", fwd_hit1, 1);
    chk("t5_data1", fwd_data1, 32'h7777_0007);
    chk("t5_hit2", fwd_hit2, 0);
    chk("t5_data2", fwd_data2, 0);
    chk("t5_cnt", wr_count, 1);
    fwd_idx2 = 5'd7;
    #1;
    chk("t5_alias_hit2", fwd_hit2, 1);
    chk("t5_alias_data2", fwd_data2, 32'h7777_0007);

    // reset with the idx7 write still staged; last_grant was A
    reset = 1'b1;
    tick();
    chk("t6_we3", we3, 0);
    chk("t6_cnt", wr_count, 0);
    chk("t6_fwd", fwd_hit1, 0);
    reset = 1'b0;
    a_valid = 1'b1; a_idx = 5'd2; a_data = 32'h2;
    b_valid = 1'b1; b_idx = 5'd4; b_data = 32'h4;
    #1;
    chk("t6_tie_a", a_ready, 1);
    chk("t6_tie_b", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t6_cnt_after", wr_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
